// File: rtl/systolic_tile_ctrl.sv
// Tile sequencer for a LANES x LANES systolic array: streams K operand vectors from the
// A/B buffers, skews them one cycle per lane, then waits for the array to drain.
module systolic_tile_ctrl #(
  parameter int LANES   = 8,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          k_len,
  output logic                busy,
  output logic                a_rd_en,
  output logic                b_rd_en,
  output logic [7:0]          a_rd_addr,
  output logic [7:0]          b_rd_addr,
  input  logic [LANES*DW-1:0] a_rd_data,
  input  logic [LANES*DW-1:0] b_rd_data,
  output logic                arr_en,
  output logic [LANES*DW-1:0] arr_activations,
  output logic [LANES*DW-1:0] arr_weights,
  output logic [LANES-1:0]    arr_done,
  input  logic [LANES-1:0]    arr_out_dones,
  output logic                tile_done,
  output logic                err
);

  localparam int FW = $clog2(LANES + 2);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]    state_r, state_nxt_s;
  logic [7:0]    k_len_r, k_len_nxt_s;
  logic [7:0]    step_r, step_nxt_s;
  logic [FW-1:0] flush_r, flush_nxt_s;
  logic [TW-1:0] drain_r, drain_nxt_s;
  logic          err_r, err_nxt_s;

  logic          busy_r;
  logic          rd_en_r;
  logic [7:0]    addr_r;
  logic          tile_done_r;
  logic          rd_vld_r;
  logic          rd_last_r;

  // Next-state and counter update logic.
  always_comb begin
    state_nxt_s = state_r;
    k_len_nxt_s = k_len_r;
    step_nxt_s  = step_r;
    flush_nxt_s = flush_r;
    drain_nxt_s = drain_r;
    err_nxt_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (k_len != 8'd0) begin
            state_nxt_s = ST_LOAD;
            k_len_nxt_s = k_len;
            step_nxt_s  = 8'd0;
            err_nxt_s   = 1'b0;
          end else begin
            state_nxt_s = ST_DONE;
            err_nxt_s   = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (step_r == 8'(k_len_r - 8'd1)) begin
          state_nxt_s = ST_FLUSH;
          flush_nxt_s = '0;
        end else begin
          step_nxt_s = step_r + 8'd1;
        end
      end
      ST_FLUSH: begin
        // LANES+1 cycles: lets the deepest skew lane emit its last element.
        if (flush_r == FW'(LANES)) begin
          state_nxt_s = ST_DRAIN;
          drain_nxt_s = '0;
        end else begin
          flush_nxt_s = flush_r + FW'(1);
        end
      end
      ST_DRAIN: begin
        if (arr_out_dones == {LANES{1'b1}}) begin
          state_nxt_s = ST_DONE;
        end else if (drain_r == TW'(TIMEOUT - 1)) begin
          state_nxt_s = ST_DONE;
          err_nxt_s   = 1'b1;
        end else begin
          drain_nxt_s = drain_r + TW'(1);
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      k_len_r <= 8'd0;
      step_r  <= 8'd0;
      flush_r <= '0;
      drain_r <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      k_len_r <= k_len_nxt_s;
      step_r  <= step_nxt_s;
      flush_r <= flush_nxt_s;
      drain_r <= drain_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  // Control outputs registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r      <= 1'b0;
      rd_en_r     <= 1'b0;
      addr_r      <= 8'd0;
      tile_done_r <= 1'b0;
    end else begin
      busy_r      <= (state_nxt_s != ST_IDLE);
      rd_en_r     <= (state_nxt_s == ST_LOAD);
      addr_r      <= (state_nxt_s == ST_LOAD) ? step_nxt_s : 8'd0;
      tile_done_r <= (state_nxt_s == ST_DONE);
    end
  end

  // Buffer read data is valid one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_r  <= 1'b0;
      rd_last_r <= 1'b0;
    end else begin
      rd_vld_r  <= rd_en_r;
      rd_last_r <= rd_en_r && (addr_r == 8'(k_len_r - 8'd1));
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DW-1:0] a_sh_r [0:i];
    logic [DW-1:0] b_sh_r [0:i];
    logic          d_sh_r [0:i];

    // Lane i delay line of i+1 stages; empty slots carry zero.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= i; j++) begin
          a_sh_r[j] <= '0;
          b_sh_r[j] <= '0;
          d_sh_r[j] <= 1'b0;
        end
      end else begin
        a_sh_r[0] <= rd_vld_r ? a_rd_data[i*DW +: DW] : '0;
        b_sh_r[0] <= rd_vld_r ? b_rd_data[i*DW +: DW] : '0;
        d_sh_r[0] <= rd_last_r;
        for (int j = 1; j <= i; j++) begin
          a_sh_r[j] <= a_sh_r[j-1];
          b_sh_r[j] <= b_sh_r[j-1];
          d_sh_r[j] <= d_sh_r[j-1];
        end
      end
    end

    assign arr_activations[i*DW +: DW] = a_sh_r[i];
    assign arr_weights[i*DW +: DW]     = b_sh_r[i];
    assign arr_done[i]                 = d_sh_r[i];
  end

  assign busy      = busy_r;
  assign arr_en    = busy_r;
  assign a_rd_en   = rd_en_r;
  assign b_rd_en   = rd_en_r;
  assign a_rd_addr = addr_r;
  assign b_rd_addr = addr_r;
  assign tile_done = tile_done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Randomized bench for systolic_tile_ctrl: per-cycle expectations come from the tile
// timing rules (cycle 0 = first LOAD cycle) applied to the bench's own buffer contents.
module tb_systolic_tile_ctrl;

  localparam int LANES   = 8;
  localparam int DW      = 16;
  localparam int TIMEOUT = 64;
  localparam int W       = LANES * DW;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       k_len;
  logic             busy;
  logic             a_rd_en, b_rd_en;
  logic [7:0]       a_rd_addr, b_rd_addr;
  logic [W-1:0]     a_rd_data, b_rd_data;
  logic             arr_en;
  logic [W-1:0]     arr_activations, arr_weights;
  logic [LANES-1:0] arr_done, arr_out_dones;
  logic             tile_done, err;

  logic [W-1:0] mem_a [0:255];
  logic [W-1:0] mem_b [0:255];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  systolic_tile_ctrl #(.LANES(LANES), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy),
    .a_rd_en(a_rd_en), .b_rd_en(b_rd_en), .a_rd_addr(a_rd_addr), .b_rd_addr(b_rd_addr),
    .a_rd_data(a_rd_data), .b_rd_data(b_rd_data), .arr_en(arr_en),
    .arr_activations(arr_activations), .arr_weights(arr_weights),
    .arr_done(arr_done), .arr_out_dones(arr_out_dones),
    .tile_done(tile_done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Synchronous-read operand buffers; garbage when not strobed.
  always @(posedge clk) begin
    a_rd_data <= a_rd_en ? mem_a[a_rd_addr] : rand_word();
    b_rd_data <= b_rd_en ? mem_b[b_rd_addr] : rand_word();
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_cycle(input int k, input int dc, input bit exp_err);
    logic [W-1:0]     ea, eb;
    logic [LANES-1:0] ed;
    int idx;
    ea = '0; eb = '0; ed = '0;
    for (int i = 0; i < LANES; i++) begin
      idx = cyc - 2 - i;
      if (idx >= 0 && idx < k) begin
        ea[i*DW +: DW] = mem_a[idx][i*DW +: DW];
        eb[i*DW +: DW] = mem_b[idx][i*DW +: DW];
      end
      if (k > 0 && cyc == k + 1 + i) ed[i] = 1'b1;
    end
    check("a_rd_en", W'(a_rd_en), W'(cyc < k));
    check("b_rd_en", W'(b_rd_en), W'(cyc < k));
    if (cyc < k) begin
      check("a_rd_addr", W'(a_rd_addr), W'(cyc));
      check("b_rd_addr", W'(b_rd_addr), W'(cyc));
    end
    check("busy", W'(busy), W'(cyc <= dc));
    check("arr_en", W'(arr_en), W'(cyc <= dc));
    check("tile_done", W'(tile_done), W'(cyc == dc));
    check("err", W'(err), W'((cyc >= dc) ? exp_err : 1'b0));
    check("arr_done", W'(arr_done), W'(ed));
    check("arr_activations", arr_activations, ea);
    check("arr_weights", arr_weights, eb);
  endtask

  // d = DRAIN cycles before the array reports all rows done; d >= TIMEOUT means never.
  task automatic run_tile(input int k, input int d, input bit restart, input bit fill);
    int d0, dc;
    bit timed_out;
    if (fill) begin
      for (int m = 0; m < 256; m++) begin
        mem_a[m] = rand_word();
        mem_b[m] = rand_word();
      end
    end
    d0 = k + LANES + 1;
    timed_out = (k > 0) && (d >= TIMEOUT);
    if (k == 0)         dc = 0;
    else if (timed_out) dc = d0 + TIMEOUT;
    else                dc = d0 + d + 1;
    @(negedge clk);
    start = 1'b1;
    k_len = 8'(k);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= dc + 1; c++) begin
      cyc = c;
      if (c < d0)                           arr_out_dones = 8'($urandom);
      else if (!timed_out && c >= d0 + d)   arr_out_dones = 8'hFF;
      else                                  arr_out_dones = 8'($urandom_range(0, 254));
      if (restart && c < dc && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        k_len = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      check_cycle(k, dc, (k == 0) || timed_out);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    bit seen_td;
    rst = 1'b1;
    start = 1'b0;
    k_len = 8'd0;
    arr_out_dones = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_rd_en", W'(a_rd_en | b_rd_en), W'(0));
    check("rst_outputs", arr_activations | arr_weights, '0);
    check("rst_flags", W'({tile_done, err, arr_en, arr_done}), W'(0));
    rst = 1'b0;

    // K=1 walking pattern; the array answers one cycle into DRAIN -> tile_done at cycle 12.
    for (int i = 0; i < LANES; i++) begin
      mem_a[0][i*DW +: DW] = DW'(i + 1);
      mem_b[0][i*DW +: DW] = DW'(16 + i);
    end
    run_tile(1, 1, 1'b0, 1'b0);
    run_tile(4, 0, 1'b0, 1'b1);
    run_tile(3, TIMEOUT, 1'b0, 1'b1);       // timeout sets err
    run_tile(2, 0, 1'b0, 1'b1);             // err cleared by next start
    run_tile(3, TIMEOUT - 1, 1'b0, 1'b1);   // answer in the last allowed DRAIN cycle
    run_tile(0, 0, 1'b0, 1'b1);             // zero-length request
    run_tile(8, 2, 1'b1, 1'b1);             // start re-pulsed while busy
    run_tile(255, 3, 1'b0, 1'b1);

    // Reset in FLUSH of a K=5 tile.
    for (int m = 0; m < 8; m++) mem_a[m] = rand_word();
    arr_out_dones = 8'h00;
    @(negedge clk);
    start = 1'b1;
    k_len = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = -1;
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_rd_en", W'(a_rd_en | b_rd_en), W'(0));
    check("midrst_addr", W'({a_rd_addr, b_rd_addr}), W'(0));
    check("midrst_operands", arr_activations | arr_weights, '0);
    check("midrst_flags", W'({tile_done, err, arr_en, arr_done}), W'(0));
    seen_td = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (tile_done || busy) seen_td = 1'b1;
    end
    check("midrst_no_tile_done", W'(seen_td), W'(0));
    run_tile(3, 0, 1'b0, 1'b1);

    for (int t = 0; t < 20; t++) begin
      int k, d;
      k = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(1, 40);
      d = ($urandom_range(0, 5) == 0) ? TIMEOUT : $urandom_range(0, 20);
      run_tile(k, d, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
